// File: rtl/serial_word_deserializer_if.sv
// serial_word_deserializer_if: serial input stream and buffered word handshake
// The DUT takes the slave side; the upstream shifter and downstream consumer take the master side.
interface serial_word_deserializer_if #(
  parameter int WORD_LENGTH = 8,
  parameter int CNT_WIDTH   = $clog2(WORD_LENGTH + 1)
);
  logic                   start;
  logic                   serialInput;
  logic                   shift;
  logic                   wordReady;
  logic [WORD_LENGTH-1:0] parallelOutput;
  logic                   wordValid;
  logic                   busy;
  logic [CNT_WIDTH-1:0]   bitCount;
  logic                   overrun;
  modport slave (
    input  start, serialInput, shift, wordReady,
    output parallelOutput, wordValid, busy, bitCount, overrun
  );
  modport master (
    output start, serialInput, shift, wordReady,
    input  parallelOutput, wordValid, busy, bitCount, overrun
  );
endinterface

// File: rtl/serial_word_deserializer.sv
// serial_word_deserializer: rebuilds WORD_LENGTH-bit words from a serial stream
// and offers each completed word through a one-deep valid/ready buffer.
module serial_word_deserializer #(
  parameter int WORD_LENGTH = 8,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int CNT_WIDTH   = $clog2(WORD_LENGTH + 1)
) (
  input logic                      clk,
  input logic                      reset,
  input logic                      sys_reset,
  serial_word_deserializer_if.slave bus
);
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t                 state_q, state_d;
  logic [WORD_LENGTH-1:0] capture_q, capture_d;
  logic [CNT_WIDTH-1:0]   bit_count_q, bit_count_d;
  logic [WORD_LENGTH-1:0] parallel_q, parallel_d;
  logic                   valid_q, valid_d;
  logic                   overrun_q, overrun_d;
  logic [WORD_LENGTH-1:0] shifted;
  logic                   last_bit;
  logic                   buffer_free;
  assign shifted     = MSB_FIRST ? {capture_q[WORD_LENGTH-2:0], bus.serialInput}
                                 : {bus.serialInput, capture_q[WORD_LENGTH-1:1]};
  assign last_bit    = bit_count_q == CNT_WIDTH'(WORD_LENGTH - 1);
  // The buffer can take a new word if it is empty or being drained this very cycle.
  assign buffer_free = !valid_q || bus.wordReady;
  always_comb begin
    state_d     = state_q;
    capture_d   = capture_q;
    bit_count_d = bit_count_q;
    parallel_d  = parallel_q;
    valid_d     = valid_q && !bus.wordReady;
    overrun_d   = overrun_q;
    if (sys_reset) begin
      state_d     = IDLE;
      capture_d   = '0;
      bit_count_d = '0;
      parallel_d  = '0;
      valid_d     = 1'b0;
      overrun_d   = 1'b0;
    end else if (state_q == IDLE) begin
      if (bus.start) begin
        state_d     = COLLECT;
        capture_d   = '0;
        bit_count_d = '0;
      end
    end else if (bus.shift) begin
      capture_d   = shifted;
      bit_count_d = last_bit ? '0 : CNT_WIDTH'(bit_count_q + 1'b1);
      state_d     = last_bit ? IDLE : COLLECT;
      if (last_bit && buffer_free) begin
        parallel_d = shifted;
        valid_d    = 1'b1;
      end
      overrun_d = overrun_q || (last_bit && !buffer_free);
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      capture_q   <= '0;
      bit_count_q <= '0;
      parallel_q  <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      capture_q   <= capture_d;
      bit_count_q <= bit_count_d;
      parallel_q  <= parallel_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end
  assign bus.parallelOutput = parallel_q;
  assign bus.wordValid      = valid_q;
  assign bus.busy           = state_q == COLLECT;
  assign bus.bitCount       = bit_count_q;
  assign bus.overrun        = overrun_q;
endmodule

// File: tb/tb_serial_word_deserializer.sv
// tb_serial_word_deserializer: directed checks of an MSB-first and an LSB-first
// deserializer fed the same stimulus.
module tb_serial_word_deserializer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sys_reset = 1'b0;
  logic start = 1'b0;
  logic serial_in = 1'b0;
  logic shift = 1'b0;
  logic ready = 1'b0;
  int   checks = 0;
  int   failures = 0;
  always #5 clk = ~clk;
  serial_word_deserializer_if #(.WORD_LENGTH(8)) ia ();
  serial_word_deserializer_if #(.WORD_LENGTH(8)) ib ();
  assign ia.start = start;
  assign ia.serialInput = serial_in;
  assign ia.shift = shift;
  assign ia.wordReady = ready;
  assign ib.start = start;
  assign ib.serialInput = serial_in;
  assign ib.shift = shift;
  assign ib.wordReady = ready;
  serial_word_deserializer #(.WORD_LENGTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .sys_reset(sys_reset), .bus(ia.slave));
  serial_word_deserializer #(.WORD_LENGTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .sys_reset(sys_reset), .bus(ib.slave));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic shift_bit(input logic b);
    serial_in = b;
    shift = 1'b1;
    tick();
    shift = 1'b0;
  endtask
  task automatic send_word(input logic [7:0] w);
    do_start();
    for (int i = 0; i < 8; i++) shift_bit(w[7-i]);
  endtask
  task automatic test_reset();
    #1;
    reset = 1'b1;
    start = 1'b1; shift = 1'b1; serial_in = 1'b1; ready = 1'b1;
    #2;
    checks++; if ({ia.parallelOutput, ia.wordValid, ia.busy, ia.bitCount, ia.overrun} !== 16'h0) begin failures++; $display("FAIL reset_async outputs got=%h exp=0", {ia.parallelOutput, ia.wordValid, ia.busy, ia.bitCount, ia.overrun}); end
    tick(); tick();
    start = 1'b0; shift = 1'b0; serial_in = 1'b0; ready = 1'b0;
    reset = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      serial_in = i[0];
      shift_bit(serial_in);
    end
    checks++; if (ia.bitCount !== 4'd0) begin failures++; $display("FAIL idle_shift bitCount got=%0d exp=0", ia.bitCount); end
    checks++; if (ia.busy !== 1'b0) begin failures++; $display("FAIL idle_shift busy got=%b exp=0", ia.busy); end
    checks++; if (ia.wordValid !== 1'b0) begin failures++; $display("FAIL idle_shift wordValid got=%b exp=0", ia.wordValid); end
  endtask
  task automatic test_basic();
    logic [7:0] w = 8'hA5;
    ready = 1'b1;
    do_start();
    checks++; if (ia.busy !== 1'b1) begin failures++; $display("FAIL basic busy_after_start got=%b exp=1", ia.busy); end
    for (int i = 0; i < 8; i++) begin
      shift_bit(w[7-i]);
      if (i < 7) begin
        checks++; if (ia.bitCount !== 4'(i + 1) || ia.wordValid !== 1'b0) begin failures++; $display("FAIL basic count bit%0d got=%0d/%b exp=%0d/0", i, ia.bitCount, ia.wordValid, i + 1); end
      end
    end
    checks++; if (ia.wordValid !== 1'b1) begin failures++; $display("FAIL basic wordValid got=%b exp=1", ia.wordValid); end
    checks++; if (ia.parallelOutput !== 8'hA5) begin failures++; $display("FAIL basic word got=%h exp=a5", ia.parallelOutput); end
    checks++; if (ia.busy !== 1'b0 || ia.bitCount !== 4'd0) begin failures++; $display("FAIL basic busy/count got=%b/%0d exp=0/0", ia.busy, ia.bitCount); end
    tick();
    checks++; if (ia.wordValid !== 1'b0) begin failures++; $display("FAIL basic one_cycle_valid got=%b exp=0", ia.wordValid); end
  endtask
  task automatic test_gaps();
    logic [7:0] w = 8'hA5;
    logic [7:0] l = 8'h80;
    ready = 1'b1;
    do_start();
    for (int i = 0; i < 8; i++) begin
      shift_bit(w[7-i]);
      if (i < 7) begin
        for (int g = 0; g < i % 4; g++) tick();
        checks++; if (ia.bitCount !== 4'(i + 1)) begin failures++; $display("FAIL gaps count bit%0d got=%0d exp=%0d", i, ia.bitCount, i + 1); end
      end
    end
    checks++; if (ia.wordValid !== 1'b1 || ia.parallelOutput !== 8'hA5) begin failures++; $display("FAIL gaps word got=%b/%h exp=1/a5", ia.wordValid, ia.parallelOutput); end
    tick();
    do_start();
    for (int i = 0; i < 8; i++) begin
      shift_bit(l[7-i]);
      if (i < 7) for (int g = 0; g < (i + 1) % 4; g++) tick();
    end
    checks++; if (ib.wordValid !== 1'b1 || ib.parallelOutput !== 8'h01) begin failures++; $display("FAIL lsb_first word got=%b/%h exp=1/01", ib.wordValid, ib.parallelOutput); end
    checks++; if (ia.parallelOutput !== 8'h80) begin failures++; $display("FAIL msb_first same_stream got=%h exp=80", ia.parallelOutput); end
    tick();
  endtask
  task automatic test_overrun();
    ready = 1'b0;
    send_word(8'h3C);
    checks++; if (ia.wordValid !== 1'b1 || ia.parallelOutput !== 8'h3C || ia.overrun !== 1'b0) begin failures++; $display("FAIL overrun first got=%b/%h/%b exp=1/3c/0", ia.wordValid, ia.parallelOutput, ia.overrun); end
    send_word(8'hFF);
    checks++; if (ia.overrun !== 1'b1) begin failures++; $display("FAIL overrun flag got=%b exp=1", ia.overrun); end
    checks++; if (ia.wordValid !== 1'b1 || ia.parallelOutput !== 8'h3C) begin failures++; $display("FAIL overrun hold got=%b/%h exp=1/3c", ia.wordValid, ia.parallelOutput); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    checks++; if (ia.wordValid !== 1'b0 || ia.overrun !== 1'b1) begin failures++; $display("FAIL overrun drain got=%b/%b exp=0/1", ia.wordValid, ia.overrun); end
    tick(); tick();
    checks++; if (ia.overrun !== 1'b1) begin failures++; $display("FAIL overrun sticky got=%b exp=1", ia.overrun); end
    sys_reset = 1'b1;
    tick();
    sys_reset = 1'b0;
    checks++; if (ia.overrun !== 1'b0) begin failures++; $display("FAIL overrun sys_reset_clear got=%b exp=0", ia.overrun); end
  endtask
  task automatic test_back_to_back();
    logic [7:0] w = 8'h81;
    ready = 1'b0;
    send_word(8'h3C);
    do_start();
    for (int i = 0; i < 7; i++) shift_bit(w[7-i]);
    ready = 1'b1;
    shift_bit(w[0]);
    ready = 1'b0;
    checks++; if (ia.overrun !== 1'b0) begin failures++; $display("FAIL same_cycle overrun got=%b exp=0", ia.overrun); end
    checks++; if (ia.wordValid !== 1'b1 || ia.parallelOutput !== 8'h81) begin failures++; $display("FAIL same_cycle reload got=%b/%h exp=1/81", ia.wordValid, ia.parallelOutput); end
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask
  task automatic test_sys_reset();
    logic [7:0] w = 8'h5A;
    ready = 1'b0;
    send_word(8'h3C);
    do_start();
    for (int i = 0; i < 5; i++) shift_bit(1'b1);
    checks++; if (ia.bitCount !== 4'd5 || ia.wordValid !== 1'b1) begin failures++; $display("FAIL sysrst pre got=%0d/%b exp=5/1", ia.bitCount, ia.wordValid); end
    sys_reset = 1'b1;
    tick();
    sys_reset = 1'b0;
    checks++; if (ia.busy !== 1'b0 || ia.bitCount !== 4'd0 || ia.wordValid !== 1'b0 || ia.parallelOutput !== 8'h00) begin failures++; $display("FAIL sysrst clear got=%b/%0d/%b/%h exp=0/0/0/00", ia.busy, ia.bitCount, ia.wordValid, ia.parallelOutput); end
    send_word(8'h3C);
    do_start();
    for (int i = 0; i < 5; i++) shift_bit(1'b0);
    #2;
    reset = 1'b1;
    #1;
    checks++; if (ia.busy !== 1'b0 || ia.bitCount !== 4'd0 || ia.wordValid !== 1'b0 || ia.parallelOutput !== 8'h00) begin failures++; $display("FAIL asyncrst clear got=%b/%0d/%b/%h exp=0/0/0/00", ia.busy, ia.bitCount, ia.wordValid, ia.parallelOutput); end
    #1;
    reset = 1'b0;
    tick();
    ready = 1'b1;
    do_start();
    for (int i = 0; i < 8; i++) shift_bit(w[7-i]);
    checks++; if (ia.wordValid !== 1'b1 || ia.parallelOutput !== 8'h5A) begin failures++; $display("FAIL fresh word got=%b/%h exp=1/5a", ia.wordValid, ia.parallelOutput); end
    checks++; if (ib.parallelOutput !== 8'h5A) begin failures++; $display("FAIL fresh lsb word got=%h exp=5a", ib.parallelOutput); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_back_to_back();
    test_sys_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_word_deserializer.md
Name: serial_word_deserializer

Overview:
Serial-to-parallel receiver that collects a bit stream produced by the team's left-shifting, parallel-load shift register, MSB first by default, and rebuilds WORD_LENGTH-bit words. Each completed word moves into a one-deep output buffer and is offered downstream with a valid/ready handshake. The capture register keeps accepting bits while the buffer waits. Sits at the receive end of the multiplier operand/result serial links.

Parameters:
WORD_LENGTH, 8, bits per word (>= 2)
MSB_FIRST, 1, 1 = first received bit lands in bit WORD_LENGTH-1; 0 = first received bit lands in bit 0
CNT_WIDTH, $clog2(WORD_LENGTH+1), width of bitCount

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
sys_reset  input  1  synchronous clear, active-high; priority over all other inputs except reset
start  input  1  begin collecting one word
serialInput  input  1  serial data bit
shift  input  1  serialInput is valid this cycle
wordReady  input  1  downstream accepts the buffered word
parallelOutput  output  WORD_LENGTH  buffered word
wordValid  output  1  parallelOutput holds an unconsumed word
busy  output  1  FSM is in COLLECT
bitCount  output  CNT_WIDTH  bits captured in the current word
overrun  output  1  sticky: a completed word was dropped

Behaviour:
- Reset (async reset=1, or sys_reset=1 at clk edge): FSM=IDLE, capture register=0, bitCount=0, parallelOutput=0, wordValid=0, busy=0, overrun=0. reset mid-word discards the partial word and any buffered word.
- FSM IDLE: shift is ignored. start=1 -> COLLECT, capture register=0, bitCount=0. A bit presented with shift=1 in the same cycle as start is not captured.
- FSM COLLECT: start is ignored. Each cycle with shift=1 captures serialInput and increments bitCount.
  - MSB_FIRST=1: capture <= {capture[WORD_LENGTH-2:0], serialInput}.
  - MSB_FIRST=0: capture <= {serialInput, capture[WORD_LENGTH-1:1]}.
  - Cycles with shift=0 hold the capture register and bitCount.
- Word completion: shift=1 while bitCount==WORD_LENGTH-1. At that edge the FSM returns to IDLE and bitCount returns to 0. The full word, including the final bit, is offered to the buffer at the same edge.
  - Buffer free (wordValid=0, or wordValid&&wordReady this cycle): parallelOutput <= word, wordValid <= 1.
  - Buffer occupied (wordValid=1, wordReady=0): the word is dropped, parallelOutput and wordValid are unchanged, overrun <= 1.
- Latency: wordValid rises on the edge that captures the last bit and is visible in the following cycle.
- Handshake: wordValid stays 1 and parallelOutput stays stable until a cycle with wordValid&&wordReady. wordValid then falls at that edge unless a completion reloads the buffer at the same edge. wordReady with wordValid=0 has no effect.
- overrun is cleared only by reset or sys_reset.
- Back-to-back words: the earliest legal start for the next word is the cycle after completion. There is no minimum gap between shift pulses.
- busy = (FSM==COLLECT), driven from a register with no combinational path from inputs. All outputs are registered.

Test Plan:
1. Assert reset with the inputs toggling -> every output reads 0 immediately, before any clk edge. Release reset with no start; pulse shift 10 times -> bitCount=0, busy=0, wordValid=0.
2. WORD_LENGTH=8, MSB_FIRST=1, wordReady=1. start, then 8 consecutive shifts of 1,0,1,0,0,1,0,1 -> wordValid=1 for exactly one cycle starting the cycle after the 8th shift, parallelOutput=0xA5, busy falls with that edge.
3. Same word as scenario 2 with shift=0 gaps of 0-3 cycles between bits -> bitCount holds during gaps and steps 1..7; result 0xA5. Repeat with MSB_FIRST=0 and stream 1,0,0,0,0,0,0,0 -> 0x01.
4. wordReady=0. Receive 0x3C, then start and receive 0xFF -> overrun=1, parallelOutput stays 0x3C, wordValid stays 1. Raise wordReady for one cycle -> wordValid=0; overrun stays 1 until sys_reset.
5. Buffer holds 0x3C. wordReady=1 in the exact cycle the last bit of 0x81 is shifted -> no overrun, wordValid stays 1, parallelOutput=0x81 next cycle.
6. After 5 bits of a word, pulse sys_reset for one cycle -> IDLE, bitCount=0, wordValid=0. Repeat with reset pulsed between clk edges -> outputs clear asynchronously. A fresh start then receives 0x5A correctly.
